// File: rtl/reflet_ram8_dma.sv
// ============================================================================
// Module   : reflet_ram8_dma
// Purpose  : Bus master for a reflet ram8 slave. It copies a block of bytes
//            (COPY) or writes a constant byte to a block (FILL).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reflet_ram8_dma #(
  parameter int addrSize = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [addrSize-1:0] src,
  input  logic [addrSize-1:0] dst,
  input  logic [addrSize-1:0] len,
  input  logic [7:0]          fill_value,
  input  logic                abort,
  output logic                mem_enable,
  output logic [addrSize-1:0] mem_addr,
  output logic [7:0]          mem_data_out,
  output logic                mem_write_en,
  input  logic [7:0]          mem_data_in,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [addrSize-1:0] c_zero = '0;
  localparam logic [addrSize-1:0] c_one  = {{(addrSize-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_next;
  logic [addrSize-1:0] r_i;
  logic [addrSize-1:0] r_src;
  logic [addrSize-1:0] r_dst;
  logic [addrSize-1:0] r_len;
  logic                r_mode;
  logic [7:0]          r_fill;
  logic [7:0]          r_byte;
  logic                w_last;

  assign w_last = (r_i == (r_len - c_one));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == c_zero)  w_state_next = S_DONE;
          else if (mode)      w_state_next = S_WRITE;
          else                w_state_next = S_READ;
        end
      end
      S_READ:    w_state_next = abort ? S_IDLE : S_CAPTURE;
      S_CAPTURE: w_state_next = abort ? S_IDLE : S_WRITE;
      S_WRITE: begin
        if (abort)       w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
        else if (r_mode) w_state_next = S_WRITE;
        else             w_state_next = S_READ;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus outputs decode only from registered state, so inputs never reach the bus combinationally.
  always_comb begin
    mem_enable   = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = c_zero;
    mem_data_out = 8'h00;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    case (r_state)
      S_READ: begin
        mem_enable = 1'b1;
        mem_addr   = r_src + r_i;
      end
      S_WRITE: begin
        mem_enable   = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = r_dst + r_i;
        mem_data_out = r_mode ? r_fill : r_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_i     <= c_zero;
      r_src   <= c_zero;
      r_dst   <= c_zero;
      r_len   <= c_zero;
      r_mode  <= 1'b0;
      r_fill  <= 8'h00;
      r_byte  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && start) begin
        r_i    <= c_zero;
        r_src  <= src;
        r_dst  <= dst;
        r_len  <= len;
        r_mode <= mode;
        r_fill <= fill_value;
      end
      if (r_state == S_CAPTURE) r_byte <= mem_data_in;
      if (r_state == S_WRITE && !abort && !w_last) r_i <= r_i + c_one;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reflet_ram8_dma.sv
// ============================================================================
// Module   : tb_reflet_ram8_dma
// Purpose  : Table-driven bench for reflet_ram8_dma with a ram8 slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reflet_ram8_dma;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [6:0] src;
  logic [6:0] dst;
  logic [6:0] len;
  logic [7:0] fill_value;
  logic       abort;
  logic       mem_enable;
  logic [6:0] mem_addr;
  logic [7:0] mem_data_out;
  logic       mem_write_en;
  logic [7:0] mem_data_in;
  logic       busy;
  logic       done;

  logic [7:0] ram [0:127];
  logic       pre_clr;
  logic       pre_we;
  logic [6:0] pre_addr;
  logic [7:0] pre_data;
  logic       en_clr;
  int         en_cnt;
  int         n_chk;
  int         n_bad;

  always #5 clk = ~clk;

  reflet_ram8_dma #(.addrSize(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .fill_value   (fill_value),
    .abort        (abort),
    .mem_enable   (mem_enable),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .mem_data_in  (mem_data_in),
    .busy         (busy),
    .done         (done)
  );

  // Synchronous ram8 slave: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (pre_clr) begin
      for (int k = 0; k < 128; k++) ram[k] <= 8'h00;
      mem_data_in <= 8'h00;
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_enable) begin
      if (mem_write_en) ram[mem_addr] <= mem_data_out;
      mem_data_in <= ram[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (en_clr)          en_cnt <= 0;
    else if (mem_enable) en_cnt <= en_cnt + 1;
  end

  typedef struct {
    logic        mode;
    logic [6:0]  src;
    logic [6:0]  dst;
    logic [6:0]  len;
    logic [7:0]  fill;
    int          lat;
    int          en;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [6:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic preload();
    pre_clr = 1'b1;
    step();
    pre_clr = 1'b0;
    poke(7'h10, 8'hA1); poke(7'h11, 8'hB2); poke(7'h12, 8'hC3); poke(7'h13, 8'hD4);
    poke(7'h00, 8'h01); poke(7'h01, 8'h02); poke(7'h02, 8'h03); poke(7'h03, 8'h04);
    poke(7'h7E, 8'hE7); poke(7'h7F, 8'hF7);
  endtask

  task automatic launch(input logic m, input logic [6:0] s, input logic [6:0] d,
                        input logic [6:0] l, input logic [7:0] f);
    mode = m; src = s; dst = d; len = l; fill_value = f;
    start = 1'b1; en_clr = 1'b1;
    step();
    start = 1'b0; en_clr = 1'b0;
    // Scramble config so only latched values can matter.
    mode = ~m; src = ~s; dst = ~d; len = ~l; fill_value = ~f;
  endtask

  // Called one cycle after start; returns the cycle index of the done pulse.
  task automatic wait_done(output int done_cyc, output bit busy_ok);
    int cyc;
    cyc = 1;
    done_cyc = -1;
    busy_ok = 1'b1;
    while (cyc <= 400) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      step();
      cyc++;
    end
    if (done && !busy) busy_ok = 1'b0;
  endtask

  initial begin
    int  dc;
    bit  bok;
    bit  quiet;
    n_chk = 0; n_bad = 0;
    pre_clr = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; en_clr = 1'b0;

    vecs[0] = '{1'b0, 7'h10, 7'h40, 7'd4, 8'h00, 13, 8, 32'hA1B2C3D4};
    vecs[1] = '{1'b1, 7'h00, 7'h7E, 7'd4, 8'h5A,  5, 4, 32'h5A5A5A5A};
    vecs[2] = '{1'b0, 7'h10, 7'h50, 7'd0, 8'h00,  1, 0, 32'h00000000};
    vecs[3] = '{1'b0, 7'h00, 7'h01, 7'd3, 8'h00, 10, 6, 32'h01010100};
    vecs[4] = '{1'b0, 7'h7E, 7'h20, 7'd3, 8'h00, 10, 6, 32'hE7F70100};
    vecs[5] = '{1'b1, 7'h00, 7'h30, 7'd1, 8'hC3,  2, 1, 32'hC3000000};
    vecs[6] = '{1'b1, 7'h00, 7'h7F, 7'd0, 8'hAA,  1, 0, 32'hF7010203};

    // Reset with inputs unknown.
    reset = 1'b0;
    start = 1'bx; mode = 1'bx; src = 'x; dst = 'x; len = 'x; fill_value = 'x; abort = 1'bx;
    repeat (3) step();
    check("rst_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_addr", {25'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_data_out}, 32'd0);
    check("rst_we", {31'd0, mem_write_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_value = '0; abort = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_enable", {31'd0, mem_enable}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      preload();
      launch(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill);
      wait_done(dc, bok);
      check($sformatf("v%0d_done_cycle", v), dc, vecs[v].lat);
      check($sformatf("v%0d_busy_span", v), {31'd0, bok}, 32'd1);
      step();
      check($sformatf("v%0d_idle_after", v), {30'd0, busy, done}, 32'd0);
      check($sformatf("v%0d_enable_count", v), en_cnt, vecs[v].en);
      for (int k = 0; k < 4; k++) begin
        logic [6:0] a;
        a = vecs[v].dst + 7'(k);
        check($sformatf("v%0d_ram_%0h", v, a), {24'd0, ram[a]}, {24'd0, vecs[v].exp[31-8*k -: 8]});
      end
    end

    // Abort in the second WRITE of an 8-byte copy.
    preload();
    launch(1'b0, 7'h10, 7'h60, 7'd8, 8'h00);
    repeat (5) step();
    check("abort_in_write", {31'd0, mem_write_en}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (done || mem_enable || busy) quiet = 1'b0;
      step();
    end
    check("abort_quiet", {31'd0, quiet}, 32'd1);
    check("abort_ram60", {24'd0, ram[7'h60]}, 32'hA1);
    check("abort_ram61", {24'd0, ram[7'h61]}, 32'hB2);
    check("abort_ram62", {24'd0, ram[7'h62]}, 32'h00);

    // Start pulsed while busy must be ignored.
    preload();
    launch(1'b0, 7'h10, 7'h48, 7'd2, 8'h00);
    step();
    mode = 1'b1; dst = 7'h70; len = 7'd1; fill_value = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(dc, bok);
    check("restart_done_cycle", dc + 2, 32'd7);
    step();
    check("restart_ram48", {24'd0, ram[7'h48]}, 32'hA1);
    check("restart_ram49", {24'd0, ram[7'h49]}, 32'hB2);
    check("restart_ram70", {24'd0, ram[7'h70]}, 32'h00);
    check("restart_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-fill releases the bus at once.
    preload();
    launch(1'b1, 7'h00, 7'h38, 7'd8, 8'h77);
    repeat (2) step();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_bus", {29'd0, busy, mem_enable, mem_write_en}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("midrst_ram38", {24'd0, ram[7'h38]}, 32'h77);
    check("midrst_ram39", {24'd0, ram[7'h39]}, 32'h77);
    check("midrst_ram3a", {24'd0, ram[7'h3A]}, 32'h00);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
